data_memory_sized: RTL and testbench
====================================

# data_memory_sized

Parametrised successor to the word-only data memory: a byte-addressed, little-endian data RAM for the datapath's load/store stage. It supports byte, half and word accesses with sign/zero extension and byte-lane writes, and flags misaligned or out-of-range accesses. After reset, a hardware clear sweep zeroes the array and holds off requests until it completes.

## Interface
- ADDR_WIDTH, 32, width of the byte address.
- DEPTH, 256, number of 32-bit words; power of two, ≥ 2; IDX = log2(DEPTH).
- CLEAR_ON_RESET, 1, 1 = run the zeroing sweep after reset; 0 = go ready immediately, contents undefined.
- Clk  input  1  clock; all logic on posedge.
- Reset  input  1  synchronous, active-high reset.
- Address  input  ADDR_WIDTH  byte address of the access.
- WriteData  input  32  store data, right-justified for byte/half.
- MemRead  input  1  load request this cycle.
- MemWrite  input  1  store request this cycle.
- Size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- Unsigned  input  1  load extension: 1 = zero-extend, 0 = sign-extend.
- ReadData  output  32  extended load result; holds its value between loads.
- ReadValid  output  1  one-cycle pulse; ReadData is new this cycle.
- Ready  output  1  array is accepting requests.
- Fault  output  1  one-cycle pulse for a rejected request.

## Operation
- Word index is Address[IDX+1:2]. A request is **out of range** if any bit of Address[ADDR_WIDTH-1:IDX+2] is nonzero.
- A request is **misaligned** if:
  - Size = 01 and Address[0] = 1, or
  - Size = 10 and Address[1:0] ≠ 00.
- Size = 11 is always a fault.
- A request is **accepted** when Ready = 1, (MemRead | MemWrite) = 1, and the request has no fault condition.
- A faulting request leaves memory unchanged, leaves ReadValid = 0, leaves ReadData unchanged, and pulses Fault on the next cycle.
- Write lanes (little-endian):
  - Byte: lane Address[1:0] ← WriteData[7:0].
  - Half: lanes {Address[1],0} and {Address[1],1} ← WriteData[15:0].
  - Word: all four lanes ← WriteData.
  - Other lanes are untouched.
- Load extracts the same lanes and extends to 32 bits according to Unsigned.
- MemRead and MemWrite both set in the same cycle: both are performed; the load returns the pre-write contents (read-before-write).
- Requests while Ready = 0 are dropped silently: no Fault, no ReadValid, no write.
- FSM states:
  - **CLEAR**: writes zero to cell Counter each cycle. When Counter = DEPTH-1, the last cell is cleared and the FSM moves to IDLE, setting Ready.
  - **IDLE**: serves requests.
- Reset (at any time, including mid-sweep) sets state CLEAR and Counter 0, or IDLE when CLEAR_ON_RESET = 0.

## Timing
- Reset values:
  - ReadData = 0, ReadValid = 0, Fault = 0.
  - Ready = 0, or 1 when CLEAR_ON_RESET = 0.
- Ready rises at the DEPTH-th rising edge with Reset low.
- Load latency is 1 cycle: a load accepted at edge N presents ReadData with ReadValid = 1 after edge N, and ReadValid drops after edge N+1 unless another load is accepted.
- A store accepted at edge N is visible to a load accepted at edge N+1.
- Back-to-back accesses are sustained at one per cycle with no bubbles.
- Fault is asserted for exactly one cycle, after the edge that sampled the bad request.

## Configuration
- DATA_MEMORY_TRACE_EN defined: each accepted store prints the byte address and the resulting 32-bit word via $display, and each fault prints the address and Size. Simulation only.
- Not defined: no display statements are compiled. Cycle behaviour is identical either way.

## Structure
- Shared package data_memory_pkg holds:
  - the Size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD),
  - the FSM state typedef (CLEAR, IDLE).
- Sub-module load_align (combinational) takes the raw word, Address[1:0], Size and Unsigned, and returns the extended load value. The top level handles the array, byte-lane write enables, fault detection, the FSM and the output registers.

## Test plan
- Reset, then hold Reset low with DEPTH = 16 → Ready = 0 for 15 edges, = 1 after the 16th; a word load from 0x3C returns 0x00000000.
- Word store 0x80FF7F01 to 0x10 → byte loads: 0x10 signed → 0x00000001; 0x13 signed → 0xFFFFFF80; 0x12 unsigned → 0x000000FF. Half load 0x12 signed → 0xFFFF80FF.
- Byte store 0xAB to 0x11 over the word above → word load 0x10 → 0x80FFAB01; other lanes unchanged.
- Half load at 0x11, word store at 0x12, Size = 11, word load at DEPTH*4 → Fault pulses once per request; memory, ReadData and ReadValid are unchanged.
- Same-cycle MemRead + MemWrite of 0x12345678 to 0x20 holding 0 → ReadData = 0; the next load returns 0x12345678.
- Reset asserted mid-sweep at Counter = 5 → Ready stays 0 and the sweep restarts from cell 0; requests issued during the sweep produce no ReadValid and no Fault.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared definitions for the byte-addressed data memory: access-size codes
// and the clear/serve FSM state type.
package data_memory_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load extractor: picks the little-endian byte/half/word lanes
// addressed by off_i out of a raw array word and sign- or zero-extends them.
module load_align
  import data_memory_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic [31:0]        shifted;

  always_comb begin
    shifted = word_i >> {off_i, 3'b000};
    byte_s  = shifted[7:0];
    half_s  = off_i[1] ? word_i[31:16] : word_i[15:0];
    data_o  = word_i;
    case (size_i)
      SIZE_BYTE: data_o = unsigned_i ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
      SIZE_HALF: data_o = unsigned_i ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
      default:   data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_memory_sized.sv
// Byte-addressed little-endian data RAM with sized loads/stores, fault
// detection and a post-reset zeroing sweep. Optional DATA_MEMORY_TRACE_EN
// prints accepted stores and faults in simulation.
module data_memory_sized
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DEPTH          = 256,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           WriteData,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  output logic [31:0]           ReadData,
  output logic                  ReadValid,
  output logic                  Ready,
  output logic                  Fault
);

  localparam int IDX = $clog2(DEPTH);

  logic [31:0]    mem_q [DEPTH];
  state_e         state_q;
  logic [IDX-1:0] cnt_q;
  logic           ready_q;
  logic           rvalid_q;
  logic           fault_q;
  logic [31:0]    rdata_q;

  logic [IDX-1:0] idx;
  logic           out_of_range;
  logic           misaligned;
  logic           bad_cond;
  logic           req;
  logic           accept;
  logic           reject;
  logic [31:0]    old_word;
  logic [31:0]    wr_rep;
  logic [3:0]     be;
  logic [31:0]    wr_word_d;
  logic [31:0]    load_val;

  assign idx          = Address[IDX+1:2];
  assign out_of_range = |(Address >> (IDX + 2));
  assign misaligned   = ((Size == SIZE_HALF) && Address[0]) ||
                        ((Size == SIZE_WORD) && (Address[1:0] != 2'b00));
  assign bad_cond     = out_of_range || misaligned || (Size == 2'b11);
  assign req          = MemRead || MemWrite;
  assign accept       = ready_q && req && !bad_cond;
  assign reject       = ready_q && req && bad_cond;
  assign old_word     = mem_q[idx];

  // Store data is replicated across lanes so the byte enables alone select it.
  always_comb begin
    be     = 4'b0000;
    wr_rep = WriteData;
    case (Size)
      SIZE_BYTE: begin
        be[Address[1:0]] = 1'b1;
        wr_rep = {4{WriteData[7:0]}};
      end
      SIZE_HALF: begin
        be     = Address[1] ? 4'b1100 : 4'b0011;
        wr_rep = {2{WriteData[15:0]}};
      end
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    wr_word_d = old_word;
    for (int l = 0; l < 4; l++) begin
      if (be[l]) wr_word_d[8*l +: 8] = wr_rep[8*l +: 8];
    end
  end

  load_align u_load_align (
    .word_i     (old_word),
    .off_i      (Address[1:0]),
    .size_i     (Size),
    .unsigned_i (Unsigned),
    .data_o     (load_val)
  );

  always_ff @(posedge Clk) begin
    if (state_q == CLEAR) begin
      mem_q[cnt_q] <= 32'd0;
    end else if (!Reset && accept && MemWrite) begin
      mem_q[idx] <= wr_word_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q    <= '0;
      ready_q  <= (CLEAR_ON_RESET == 0);
      rvalid_q <= 1'b0;
      fault_q  <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      rvalid_q <= accept && MemRead;
      fault_q  <= reject;
      if (accept && MemRead) rdata_q <= load_val;
      case (state_q)
        CLEAR: begin
          cnt_q <= cnt_q + IDX'(1);
          if (cnt_q == IDX'(DEPTH - 1)) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DATA_MEMORY_TRACE_EN
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      if (accept && MemWrite)
        $display("[data_memory] store addr=0x%h word=0x%08h", Address, wr_word_d);
      if (reject)
        $display("[data_memory] fault addr=0x%h size=%b", Address, Size);
    end
  end
`endif

  assign ReadData  = rdata_q;
  assign ReadValid = rvalid_q;
  assign Ready     = ready_q;
  assign Fault     = fault_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized with DEPTH = 16: clear sweep, sized
// loads/stores, fault cases, read-before-write and mid-sweep reset.
module tb_data_memory_sized;

  localparam int AW    = 32;
  localparam int DEPTH = 16;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [AW-1:0] Address;
  logic [31:0]   WriteData;
  logic          MemRead, MemWrite;
  logic [1:0]    Size;
  logic          Unsigned;
  logic [31:0]   ReadData;
  logic          ReadValid, Ready, Fault;

  int tests = 0;
  int fails = 0;

  data_memory_sized #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Address   (Address),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Size      (Size),
    .Unsigned  (Unsigned),
    .ReadData  (ReadData),
    .ReadValid (ReadValid),
    .Ready     (Ready),
    .Fault     (Fault)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_valid;
    logic        exp_fault;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    MemRead = rd; MemWrite = wr; Size = sz; Unsigned = uns; Address = a; WriteData = wd;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input string n, input logic rd, input logic wr, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, input logic [31:0] wd,
                     input logic ev, input logic ef, input logic [31:0] ed);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
    v.exp_valid = ev; v.exp_fault = ef; v.exp_data = ed;
    vecs.push_back(v);
  endtask

  initial begin
    int hi_cnt;
    add("st_word_10",   0, 1, 2'b10, 0, 32'h10, 32'h80FF7F01, 0, 0, 32'h00000000);
    add("ld_b10_s",     1, 0, 2'b00, 0, 32'h10, 32'h0,        1, 0, 32'h00000001);
    add("ld_b13_s",     1, 0, 2'b00, 0, 32'h13, 32'h0,        1, 0, 32'hFFFFFF80);
    add("ld_b12_u",     1, 0, 2'b00, 1, 32'h12, 32'h0,        1, 0, 32'h000000FF);
    add("ld_h12_s",     1, 0, 2'b01, 0, 32'h12, 32'h0,        1, 0, 32'hFFFF80FF);
    add("ld_h12_u",     1, 0, 2'b01, 1, 32'h12, 32'h0,        1, 0, 32'h000080FF);
    add("st_b11",       0, 1, 2'b00, 0, 32'h11, 32'h000000AB, 0, 0, 32'h000080FF);
    add("ld_w10_merge", 1, 0, 2'b10, 0, 32'h10, 32'h0,        1, 0, 32'h80FFAB01);
    add("flt_h11",      1, 0, 2'b01, 0, 32'h11, 32'h0,        0, 1, 32'h80FFAB01);
    add("flt_st_w12",   0, 1, 2'b10, 0, 32'h12, 32'hDEADBEEF, 0, 1, 32'h80FFAB01);
    add("flt_size11",   1, 0, 2'b11, 0, 32'h10, 32'h0,        0, 1, 32'h80FFAB01);
    add("flt_oor_40",   1, 0, 2'b10, 0, 32'h40, 32'h0,        0, 1, 32'h80FFAB01);
    add("ld_w10_kept",  1, 0, 2'b10, 0, 32'h10, 32'h0,        1, 0, 32'h80FFAB01);
    add("ld_w20_zero",  1, 0, 2'b10, 0, 32'h20, 32'h0,        1, 0, 32'h00000000);
    add("ld_b12_u2",    1, 0, 2'b00, 1, 32'h12, 32'h0,        1, 0, 32'h000000FF);
    add("rw_w20",       1, 1, 2'b10, 0, 32'h20, 32'h12345678, 1, 0, 32'h00000000);
    add("ld_w20_new",   1, 0, 2'b10, 0, 32'h20, 32'h0,        1, 0, 32'h12345678);
    add("idle_hold",    0, 0, 2'b10, 0, 32'h0,  32'h0,        0, 0, 32'h12345678);

    // Reset and clear sweep
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    Reset = 1'b1;
    tick();
    tick();
    check("rst_ReadData",  ReadData, 32'h0);
    check("rst_ReadValid", {31'd0, ReadValid}, 32'd0);
    check("rst_Fault",     {31'd0, Fault}, 32'd0);
    check("rst_Ready",     {31'd0, Ready}, 32'd0);
    Reset = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      tick();
      if (Ready) hi_cnt++;
    end
    check("sweep_ready_low_edges", hi_cnt, 0);
    tick();
    check("sweep_ready_at_depth", {31'd0, Ready}, 32'd1);

    drive(1, 0, 2'b10, 0, 32'h3C, 32'h0);
    tick();
    check("ld_w3c_valid", {31'd0, ReadValid}, 32'd1);
    check("ld_w3c_data",  ReadData, 32'h0);
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    tick();
    check("ld_w3c_valid_drop", {31'd0, ReadValid}, 32'd0);

    // Table-driven back-to-back vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      tick();
      check({vecs[i].name, "_valid"}, {31'd0, ReadValid}, {31'd0, vecs[i].exp_valid});
      check({vecs[i].name, "_fault"}, {31'd0, Fault}, {31'd0, vecs[i].exp_fault});
      check({vecs[i].name, "_data"},  ReadData, vecs[i].exp_data);
    end

    // Mid-sweep reset at Counter = 5, with requests issued throughout
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    Reset = 1'b1;
    tick();
    check("rst2_ReadData", ReadData, 32'h0);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (i % 2 == 0) drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
      else            drive(1, 1, 2'b11, 0, 32'h11, 32'hFFFFFFFF);
      tick();
      if (Ready || ReadValid || Fault) hi_cnt++;
    end
    check("sweep2_quiet_edges", hi_cnt, 0);
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    tick();
    check("sweep2_ready", {31'd0, Ready}, 32'd1);
    check("sweep2_no_fault", {31'd0, Fault}, 32'd0);

    drive(1, 0, 2'b10, 0, 32'h10, 32'h0);
    tick();
    check("sweep2_w10_valid", {31'd0, ReadValid}, 32'd1);
    check("sweep2_w10_cleared", ReadData, 32'h0);
    drive(1, 0, 2'b10, 0, 32'h20, 32'h0);
    tick();
    check("sweep2_w20_cleared", ReadData, 32'h0);
    drive(0, 0, 2'b10, 0, 32'h0, 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
